// File: rtl/multiword_add_seq.sv
// Multi-word adder/subtractor that reuses one 4-bit ripple-carry slice over WORDS cycles.
// The slices are processed least-significant first, and a registered carry links each slice to the next.
module multiword_add_seq #(
    parameter  int unsigned WORDS = 4,
    localparam int unsigned WIDTH = 4 * WORDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [3:0]       slice_a, slice_b;
    logic [4:0]       slice_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // B is stored already inverted for subtract, so the slice only ever adds.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        slice_a   = a_q[{idx_q, 2'b00} +: 4];
        slice_b   = b_q[{idx_q, 2'b00} +: 4];
        slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {4'b0000, carry_q};

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = op_a;
                    b_d      = sub ? ~op_b : op_b;
                    carry_d  = sub;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = slice_sum[3:0];
                carry_d = slice_sum[4];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(WORDS - 1)) begin
                    cout_d  = slice_sum[4];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq, with one WORDS=4 instance and one WORDS=1 instance.
// Expected results are queued when a start is driven and are popped on each done pulse.
module tb_multiword_add_seq;

    typedef struct {
        logic [15:0] res;
        logic        c;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start4 = 1'b0, sub4 = 1'b0;
    logic [15:0] op_a4 = '0, op_b4 = '0;
    logic        busy4, done4, cout4, ovf4;
    logic [15:0] result4;

    logic        start1 = 1'b0, sub1 = 1'b0;
    logic [3:0]  op_a1 = '0, op_b1 = '0;
    logic        busy1, done1, cout1, ovf1;
    logic [3:0]  result1;

    int n_checks = 0;
    int n_pass   = 0;
    int acc4 = 0, acc1 = 0, dn4 = 0, dn1 = 0;
    exp_t q4[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    multiword_add_seq #(.WORDS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4),
        .op_a(op_a4), .op_b(op_b4), .busy(busy4), .done(done4),
        .result(result4), .cout(cout4), .overflow(ovf4)
    );

    multiword_add_seq #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1),
        .op_a(op_a1), .op_b(op_b1), .busy(busy1), .done(done1),
        .result(result1), .cout(cout1), .overflow(ovf1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: a single full-width add, independent of the slicing.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s, input int unsigned w);
        logic [16:0] mask, am, bm, sum;
        exp_t e;
        mask  = (17'd1 << w) - 17'd1;
        am    = {1'b0, a} & mask;
        bm    = {1'b0, (s ? ~b : b)} & mask;
        sum   = am + bm + {16'd0, s};
        e.res = sum[15:0] & mask[15:0];
        e.c   = sum[w];
        e.v   = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done4) begin
            dn4++;
            if (q4.size() == 0)
                check("w4 spurious done", 1, 0);
            else begin
                exp_t e;
                e = q4.pop_front();
                check("w4 result", {16'd0, result4}, {16'd0, e.res});
                check("w4 cout", {31'd0, cout4}, {31'd0, e.c});
                check("w4 overflow", {31'd0, ovf4}, {31'd0, e.v});
            end
        end
        if (rst_n && done1) begin
            dn1++;
            if (q1.size() == 0)
                check("w1 spurious done", 1, 0);
            else begin
                exp_t e;
                e = q1.pop_front();
                check("w1 result", {28'd0, result1}, {16'd0, e.res});
                check("w1 cout", {31'd0, cout1}, {31'd0, e.c});
                check("w1 overflow", {31'd0, ovf1}, {31'd0, e.v});
            end
        end
    end

    // Call at a negedge; returns at a negedge with the WORDS=4 unit idle.
    task automatic wait_idle4();
        int g = 0;
        while (busy4 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("w4 idle timeout", 0, 1);
    endtask

    task automatic wait_idle1();
        int g = 0;
        while (busy1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) check("w1 idle timeout", 0, 1);
    endtask

    task automatic issue4(input logic [15:0] a, input logic [15:0] b, input logic s, input bit push);
        start4 = 1'b1; op_a4 = a; op_b4 = b; sub4 = s;
        if (push) begin
            q4.push_back(model(a, b, s, 16));
            acc4++;
        end
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic issue1(input logic [3:0] a, input logic [3:0] b, input logic s);
        start1 = 1'b1; op_a1 = a; op_b1 = b; sub1 = s;
        q1.push_back(model({12'd0, a}, {12'd0, b}, s, 4));
        acc1++;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;

        @(negedge clk);
        check("rst busy", {31'd0, busy4}, 0);
        check("rst done", {31'd0, done4}, 0);
        check("rst result", {16'd0, result4}, 0);
        check("rst cout", {31'd0, cout4}, 0);
        check("rst overflow", {31'd0, ovf4}, 0);
        check("rst w1 busy", {31'd0, busy1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency and busy window
        issue4(16'h1234, 16'h4321, 1'b0, 1'b1);
        check("lat busy after accept", {31'd0, busy4}, 1);
        check("lat done after accept", {31'd0, done4}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("lat done", {31'd0, done4}, (k == 4) ? 32'd1 : 32'd0);
            check("lat busy", {31'd0, busy4}, (k < 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("done single cycle", {31'd0, done4}, 0);
        repeat (2) @(negedge clk);
        check("result holds", {16'd0, result4}, 32'h5555);

        issue4(16'hFFFF, 16'h0001, 1'b0, 1'b1); wait_idle4();
        issue4(16'h7FFF, 16'h0001, 1'b0, 1'b1); wait_idle4();
        issue4(16'h0005, 16'h0007, 1'b1, 1'b1); wait_idle4();
        issue4(16'h1234, 16'h1234, 1'b1, 1'b1); wait_idle4();

        // Starts while busy must be ignored; a start in the done cycle must be accepted
        issue4(16'h0001, 16'h0001, 1'b0, 1'b1);
        start4 = 1'b1; op_a4 = 16'hAAAA; op_b4 = 16'h5555; sub4 = 1'b0;
        @(negedge clk);
        op_a4 = 16'hFFFF; sub4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; op_a4 = 16'h1357;
        cyc = 0;
        while (!done4 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("busy prot done seen", {31'd0, done4}, 1);
        start4 = 1'b1; op_a4 = 16'h0010; op_b4 = 16'h0020; sub4 = 1'b0;
        q4.push_back(model(16'h0010, 16'h0020, 1'b0, 16));
        acc4++;
        cyc = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            cyc++;
        end while (!done4 && cyc < 30);
        check("b2b latency", cyc, 5);
        @(negedge clk);
        wait_idle4();

        // Leaves cout=1 and overflow=1 so that the reset clearing them is observable
        issue4(16'h8000, 16'h0001, 1'b1, 1'b1); wait_idle4();
        @(negedge clk);
        issue4(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy4}, 0);
        check("abort done", {31'd0, done4}, 0);
        check("abort result", {16'd0, result4}, 0);
        check("abort cout", {31'd0, cout4}, 0);
        check("abort overflow", {31'd0, ovf4}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("no done after abort", {31'd0, busy4 | done4}, 0);
        issue4(16'h0003, 16'h0004, 1'b0, 1'b1); wait_idle4();
        @(negedge clk);

        fork
            for (int i = 0; i < 1000; i++) begin
                wait_idle4();
                issue4(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
            end
            for (int i = 0; i < 1000; i++) begin
                wait_idle1();
                issue1(4'($urandom), 4'($urandom), 1'($urandom));
            end
        join
        wait_idle4();
        wait_idle1();
        repeat (3) @(negedge clk);

        check("w4 queue drained", q4.size(), 0);
        check("w1 queue drained", q1.size(), 0);
        check("w4 done count", dn4, acc4);
        check("w1 done count", dn1, acc1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
